matrix_result_tx_formatter: RTL and testbench

//  Output-side counterpart of the matrix core's UART receive path. On a start pulse it

---
 rtl/matrix_result_tx_formatter.sv | 192 +++++++++++++++++++
 tb/tb_matrix_result_tx_formatter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_tx_formatter.sv
// Prints a snapshot of a signed m x n matrix as ASCII decimal text, row-major,
// space-separated, CR LF per row, one byte at a time over a valid/ready link.
module matrix_result_tx_formatter #(
  parameter int unsigned MAX_DIM = 5,
  parameter int unsigned ELEM_W  = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [3:0]                          mat_m,
  input  logic [3:0]                          mat_n,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   mat_flat,
  output logic [7:0]                          tx_data,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam int unsigned NUM_EL = MAX_DIM * MAX_DIM;
  localparam int unsigned FLAT_W = NUM_EL * ELEM_W;
  localparam int unsigned MAG_W  = ELEM_W + 1;
  localparam int unsigned IDX_W  = $clog2(NUM_EL);

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_LOAD, S_SIGN, S_DIGIT, S_SEP, S_CR, S_LF, S_DONE
  } state_t;

  state_t              state;
  logic [3:0]          m_q, n_q;
  logic [FLAT_W-1:0]   mat_q;
  logic [2:0]          r, c;
  logic [MAG_W-1:0]    rem;
  logic [2:0]          pow_idx;
  logic [3:0]          dig;
  logic                started;

  logic [ELEM_W-1:0]   elems [NUM_EL];
  logic [IDX_W-1:0]    idx_c;
  logic [ELEM_W-1:0]   elem_c;
  logic [MAG_W-1:0]    ext_c, mag_c, pow_c;
  logic                xfer_c, bad_c, last_col_c, last_row_c;

  // Element select and magnitude; the extra bit lets -32768 become +32768.
  always_comb begin
    for (int k = 0; k < int'(NUM_EL); k++) elems[k] = mat_q[k*ELEM_W +: ELEM_W];
    idx_c  = IDX_W'(r) * IDX_W'(MAX_DIM) + IDX_W'(c);
    elem_c = elems[idx_c];
    ext_c  = {elem_c[ELEM_W-1], elem_c};
    mag_c  = elem_c[ELEM_W-1] ? (~ext_c + MAG_W'(1)) : ext_c;
  end

  always_comb begin
    case (pow_idx)
      3'd0:    pow_c = MAG_W'(10000);
      3'd1:    pow_c = MAG_W'(1000);
      3'd2:    pow_c = MAG_W'(100);
      3'd3:    pow_c = MAG_W'(10);
      default: pow_c = MAG_W'(1);
    endcase
  end

  assign xfer_c     = tx_valid && tx_ready;
  assign bad_c      = (m_q == 4'd0) || (m_q > 4'(MAX_DIM)) ||
                      (n_q == 4'd0) || (n_q > 4'(MAX_DIM));
  assign last_col_c = ({1'b0, c} == (n_q - 4'd1));
  assign last_row_c = ({1'b0, r} == (m_q - 4'd1));

  // Each byte-sending state raises tx_valid once, then waits for the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      m_q      <= 4'd0;
      n_q      <= 4'd0;
      mat_q    <= '0;
      r        <= 3'd0;
      c        <= 3'd0;
      rem      <= '0;
      pow_idx  <= 3'd0;
      dig      <= 4'd0;
      started  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            m_q   <= mat_m;
            n_q   <= mat_n;
            mat_q <= mat_flat;
            busy  <= 1'b1;
            state <= S_CHK;
          end
        end
        S_CHK: begin
          if (bad_c) begin
            done  <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            r     <= 3'd0;
            c     <= 3'd0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          rem     <= mag_c;
          pow_idx <= 3'd0;
          dig     <= 4'd0;
          started <= 1'b0;
          state   <= elem_c[ELEM_W-1] ? S_SIGN : S_DIGIT;
        end
        S_SIGN: begin
          if (xfer_c) begin
            tx_valid <= 1'b0;
            state    <= S_DIGIT;
          end else if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h2D;
          end
        end
        S_DIGIT: begin
          if (xfer_c) begin
            tx_valid <= 1'b0;
            started  <= 1'b1;
            dig      <= 4'd0;
            if (pow_idx == 3'd4) state <= last_col_c ? S_CR : S_SEP;
            else                 pow_idx <= pow_idx + 3'd1;
          end else if (!tx_valid) begin
            if (rem >= pow_c) begin
              rem <= rem - pow_c;
              dig <= dig + 4'd1;
            end else if ((dig != 4'd0) || started || (pow_idx == 3'd4)) begin
              tx_valid <= 1'b1;
              tx_data  <= 8'h30 + 8'(dig);
            end else begin
              pow_idx <= pow_idx + 3'd1;
            end
          end
        end
        S_SEP: begin
          if (xfer_c) begin
            tx_valid <= 1'b0;
            c        <= c + 3'd1;
            state    <= S_LOAD;
          end else if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h20;
          end
        end
        S_CR: begin
          if (xfer_c) begin
            tx_valid <= 1'b0;
            state    <= S_LF;
          end else if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h0D;
          end
        end
        S_LF: begin
          if (xfer_c) begin
            tx_valid <= 1'b0;
            if (last_row_c) begin
              state <= S_DONE;
            end else begin
              r     <= r + 3'd1;
              c     <= 3'd0;
              state <= S_LOAD;
            end
          end else if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h0A;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_tx_formatter.sv
// Directed bench for matrix_result_tx_formatter: vector table of matrices with
// expected text ('|' stands for CR LF), plus stall, bad-dims, busy and reset sequences.
module tb_matrix_result_tx_formatter;

  localparam int MD = 5;
  localparam int EW = 16;
  localparam int FW = MD * MD * EW;
  localparam int NV = 5;

  logic          clk = 1'b0;
  logic          rst_n, start, tx_ready;
  logic [3:0]    mat_m, mat_n;
  logic [FW-1:0] mat_flat;
  logic [7:0]    tx_data;
  logic          tx_valid, busy, done, err;

  int checks   = 0;
  int failures = 0;
  byte unsigned got_q[$];

  typedef struct {
    int    m;
    int    n;
    int    mode;   // 0: ready always high, 1: random ready, 3: ready high + stray start
    int    e[9];
    string exp_s;
  } vec_t;

  vec_t vecs[NV];

  matrix_result_tx_formatter #(.MAX_DIM(MD), .ELEM_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mat_m(mat_m), .mat_n(mat_n),
    .mat_flat(mat_flat), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_seq(input string name, input string exp_s);
    byte unsigned eq[$];
    int bad;
    byte unsigned gb, eb;
    for (int i = 0; i < exp_s.len(); i++) begin
      if (exp_s[i] == 8'h7C) begin
        eq.push_back(8'h0D);
        eq.push_back(8'h0A);
      end else begin
        eq.push_back(exp_s[i]);
      end
    end
    bad = -1;
    for (int i = 0; i < eq.size() || i < got_q.size(); i++) begin
      if (bad < 0 && (i >= eq.size() || i >= got_q.size() || eq[i] != got_q[i])) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      gb = (bad < got_q.size()) ? got_q[bad] : 8'hFF;
      eb = (bad < eq.size()) ? eq[bad] : 8'hFF;
      $display("FAIL %s: got %0d bytes required %0d, first difference at byte %0d (got 0x%02h required 0x%02h)",
               name, got_q.size(), eq.size(), bad, gb, eb);
    end
  endtask

  function automatic logic [FW-1:0] make_flat(input vec_t v);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < v.m; i++)
      for (int j = 0; j < v.n; j++)
        f[(i*MD+j)*EW +: EW] = EW'(v.e[i*v.n+j]);
    return f;
  endfunction

  task automatic start_print(input int m, input int n, input logic [FW-1:0] f);
    @(negedge clk);
    mat_m    = 4'(m);
    mat_n    = 4'(n);
    mat_flat = f;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Records transferred bytes until 20 cycles past the first done, or budget expiry.
  task automatic capture(input int mode, output int ndone, output int nerr, output int nviol);
    int after;
    logic pv;
    logic [7:0] pd;
    after = -1;
    pv    = 1'b0;
    pd    = 8'h00;
    ndone = 0;
    nerr  = 0;
    nviol = 0;
    got_q.delete();
    for (int cyc = 0; cyc < 20000 && after != 0; cyc++) begin
      @(negedge clk);
      if (mode == 1) tx_ready = 1'($urandom_range(0, 1));
      else           tx_ready = 1'b1;
      if (mode == 3 && cyc == 10) begin
        start    = 1'b1;
        mat_m    = 4'd1;
        mat_n    = 4'd1;
        mat_flat = '0;
      end
      if (mode == 3 && cyc == 11) start = 1'b0;
      if (pv && !(tx_valid && tx_data == pd)) nviol++;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      pv = tx_valid && !tx_ready;
      pd = tx_data;
      if (done) ndone++;
      if (err) nerr++;
      if (done && after < 0) after = 20;
      else if (after > 0) after--;
    end
  endtask

  task automatic bad_dims(input int m, input int n);
    int nv;
    nv = 0;
    start_print(m, n, '1);
    check($sformatf("bad_%0dx%0d_busy", m, n), longint'(busy), 1);
    if (tx_valid) nv++;
    @(negedge clk);
    check($sformatf("bad_%0dx%0d_done_err_busy", m, n), longint'({done, err, busy}), 6);
    if (tx_valid) nv++;
    @(negedge clk);
    check($sformatf("bad_%0dx%0d_after", m, n), longint'({done, err, busy}), 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (tx_valid || done) nv++;
    end
    check($sformatf("bad_%0dx%0d_no_tx", m, n), nv, 0);
  endtask

  initial begin
    int nd, ne, nvl, seen, stable;
    logic [FW-1:0] f55;

    rst_n    = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b0;
    mat_m    = 4'd0;
    mat_n    = 4'd0;
    mat_flat = '0;

    vecs[0] = '{m:1, n:1, mode:0, e:'{0, 0, 0, 0, 0, 0, 0, 0, 0}, exp_s:"0|"};
    vecs[1] = '{m:2, n:2, mode:0, e:'{1, -2, 30, 32767, 0, 0, 0, 0, 0}, exp_s:"1 -2|30 32767|"};
    vecs[2] = '{m:1, n:2, mode:0, e:'{-32768, 100, 0, 0, 0, 0, 0, 0, 0}, exp_s:"-32768 100|"};
    vecs[3] = '{m:1, n:3, mode:1, e:'{10, -9, 1000, 0, 0, 0, 0, 0, 0}, exp_s:"10 -9 1000|"};
    vecs[4] = '{m:3, n:1, mode:1, e:'{-1, 20005, -10, 0, 0, 0, 0, 0, 0}, exp_s:"-1|20005|-10|"};

    repeat (2) @(negedge clk);
    check("reset_tx_data", longint'(tx_data), 0);
    check("reset_tx_valid", longint'(tx_valid), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_err", longint'(err), 0);
    rst_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      start_print(vecs[v].m, vecs[v].n, make_flat(vecs[v]));
      capture(vecs[v].mode, nd, ne, nvl);
      check_seq($sformatf("vec%0d_bytes", v), vecs[v].exp_s);
      check($sformatf("vec%0d_done_count", v), nd, 1);
      check($sformatf("vec%0d_err_count", v), ne, 0);
      check($sformatf("vec%0d_stall_violations", v), nvl, 0);
      check($sformatf("vec%0d_busy_end", v), longint'(busy), 0);
    end

    // Element 7 held behind a stalled transmitter.
    tx_ready = 1'b0;
    start_print(1, 1, FW'(7));
    seen = 0;
    for (int k = 0; k < 50 && seen == 0; k++) begin
      @(negedge clk);
      if (tx_valid) seen = 1;
    end
    check("stall_valid_seen", seen, 1);
    stable = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!(tx_valid && tx_data == 8'h37)) stable = 0;
    end
    check("stall_hold_0x37", stable, 1);
    capture(0, nd, ne, nvl);
    check_seq("stall_bytes", "7|");
    check("stall_done_count", nd, 1);

    bad_dims(0, 2);
    bad_dims(2, 6);

    // A second start and new inputs mid-print must not disturb or queue anything.
    start_print(vecs[1].m, vecs[1].n, make_flat(vecs[1]));
    capture(3, nd, ne, nvl);
    check_seq("busy_start_bytes", vecs[1].exp_s);
    check("busy_start_done_count", nd, 1);

    // Reset in the middle of a 5x5 print, then a full clean print.
    for (int k = 0; k < 25; k++) f55[k*EW +: EW] = EW'(k - 12);
    tx_ready = 1'b1;
    start_print(5, 5, f55);
    repeat (60) @(negedge clk);
    check("midprint_busy", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midprint_reset_outputs", longint'({tx_valid, busy, done, err, tx_data}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_print(5, 5, f55);
    capture(0, nd, ne, nvl);
    check_seq("full_5x5_bytes", "-12 -11 -10 -9 -8|-7 -6 -5 -4 -3|-2 -1 0 1 2|3 4 5 6 7|8 9 10 11 12|");
    check("full_5x5_done_count", nd, 1);
    check("full_5x5_err_count", ne, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
